// File: rtl/mem_access_ctrl.sv
// Load/store initiator for the byte-addressed RAM handshake: validates a request, holds
// memFuncActive until completion, returns extended load data. Optional WAIT timeout: MEMCTL_TIMEOUT_EN.
module mem_access_ctrl #(
    parameter int ADDR_WIDTH     = 9,
    parameter bit CHECK_ALIGN    = 1'b1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_rw,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error,
    output logic                  memFuncActive,
    output logic                  readWrite,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [31:0]           dataIn,
    output logic [1:0]            dataSize,
    input  logic                  memFuncComplete,
    input  logic [31:0]           dataOut
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                state_q, state_d;
    logic                  rw_q, rw_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [1:0]            size_q, size_d;
    logic                  signed_q, signed_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;

`ifdef MEMCTL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]      cnt_q, cnt_d;
`endif

    logic [1:0]            nb_m1;
    logic [ADDR_WIDTH:0]   last_addr;
    logic                  req_bad;
    logic [31:0]           load_data;

    // Request legality: illegal size, misalignment, then running off the end of memory.
    always_comb begin
        nb_m1 = 2'd0;
        case (req_size)
            2'b01:   nb_m1 = 2'd1;
            2'b11:   nb_m1 = 2'd3;
            default: nb_m1 = 2'd0;
        endcase
        last_addr = {1'b0, req_addr} + (ADDR_WIDTH+1)'(nb_m1);
        req_bad   = (req_size == 2'b10) || last_addr[ADDR_WIDTH];
        if (CHECK_ALIGN && (((req_size == 2'b01) && req_addr[0]) ||
                            ((req_size == 2'b11) && (req_addr[1:0] != 2'b00))))
            req_bad = 1'b1;
    end

    // Only the low bytes of dataOut are meaningful for sub-word loads.
    always_comb begin
        load_data = dataOut;
        case (size_q)
            2'b00:   load_data = {{24{signed_q & dataOut[7]}}, dataOut[7:0]};
            2'b01:   load_data = {{16{signed_q & dataOut[15]}}, dataOut[15:0]};
            default: load_data = dataOut;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        size_d   = size_q;
        signed_d = signed_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
`ifdef MEMCTL_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    rw_d     = req_rw;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    size_d   = req_size;
                    signed_d = req_signed;
                    if (req_bad) begin
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // A completion left high by the previous access is not trusted here.
                state_d = S_WAIT;
`ifdef MEMCTL_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (memFuncComplete) begin
                    err_d   = 1'b0;
                    rdata_d = rw_q ? 32'd0 : load_data;
                    state_d = S_RESP;
                end
`ifdef MEMCTL_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                err_d   = 1'b0;
                rdata_d = 32'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
`ifdef MEMCTL_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
`ifdef MEMCTL_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign req_ready     = (state_q == S_IDLE);
    assign memFuncActive = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign resp_valid    = (state_q == S_RESP);
    assign resp_rdata    = rdata_q;
    assign resp_error    = err_q;
    assign readWrite     = rw_q;
    assign address       = addr_q;
    assign dataIn        = wdata_q;
    assign dataSize      = size_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: RAM model with programmable completion delay, directed vector
// table, reset/timeout sequences, and random traffic checked against a byte-array reference.
module tb_mem_access_ctrl;
    localparam int AW  = 9;
    localparam int MEM = 512;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    always #5 Clk = ~Clk;

    logic          req_valid = 1'b0, req_rw = 1'b0, req_signed = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic [1:0]    req_size = '0;
    logic          req_ready, resp_valid, resp_error, memFuncActive, readWrite;
    logic [31:0]   resp_rdata, dataIn;
    logic [AW-1:0] address;
    logic [1:0]    dataSize;
    logic          memFuncComplete = 1'b0;
    logic [31:0]   dataOut = '0;

    // Second instance without alignment checking; its RAM side always reports completion.
    logic          n_valid = 1'b0, n_signed = 1'b0;
    logic [AW-1:0] n_addr = '0;
    logic [1:0]    n_size = '0;
    logic          n_ready, n_rvalid, n_rerr, n_active, n_rw_o;
    logic [31:0]   n_rdata, n_din;
    logic [AW-1:0] n_address;
    logic [1:0]    n_dsize;

    mem_access_ctrl #(.ADDR_WIDTH(AW), .CHECK_ALIGN(1'b1), .TIMEOUT_CYCLES(16)) dut (
        .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_signed(req_signed), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .memFuncActive(memFuncActive), .readWrite(readWrite),
        .address(address), .dataIn(dataIn), .dataSize(dataSize),
        .memFuncComplete(memFuncComplete), .dataOut(dataOut));

    mem_access_ctrl #(.ADDR_WIDTH(AW), .CHECK_ALIGN(1'b0), .TIMEOUT_CYCLES(16)) dut_na (
        .Clk(Clk), .Reset(Reset), .req_valid(n_valid), .req_ready(n_ready),
        .req_rw(1'b0), .req_addr(n_addr), .req_wdata(32'h0), .req_size(n_size),
        .req_signed(n_signed), .resp_valid(n_rvalid), .resp_rdata(n_rdata),
        .resp_error(n_rerr), .memFuncActive(n_active), .readWrite(n_rw_o),
        .address(n_address), .dataIn(n_din), .dataSize(n_dsize),
        .memFuncComplete(1'b1), .dataOut(32'hCAFE_8001));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- RAM model ----------------
    // Completion rises after ram_lat edges of memFuncActive and stays high until the next access.
    logic [7:0] ram [MEM];
    logic       ram_init = 1'b1;
    int         ram_lat = 1;
    int         act_cnt = 0;

    function automatic int nbytes(input logic [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b11:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] ram_read(input logic [AW-1:0] a, input logic [1:0] s);
        logic [31:0] v;
        v = $urandom;  // junk in bytes the access does not cover
        for (int i = 0; i < nbytes(s); i++) v[8*i +: 8] = ram[(int'(a) + i) % MEM];
        return v;
    endfunction

    always @(posedge Clk) begin
        if (ram_init) for (int i = 0; i < MEM; i++) ram[i] <= 8'h00;
        if (!memFuncActive) begin
            act_cnt <= 0;
        end else begin
            act_cnt <= act_cnt + 1;
            if (act_cnt + 1 == ram_lat) begin
                memFuncComplete <= 1'b1;
                if (readWrite)
                    for (int i = 0; i < nbytes(dataSize); i++)
                        ram[(int'(address) + i) % MEM] <= dataIn[8*i +: 8];
                else
                    dataOut <= ram_read(address, dataSize);
            end else if (act_cnt == 0) begin
                memFuncComplete <= 1'b0;
            end
        end
    end

    // ---------------- reference model ----------------
    int ref_mem [MEM];

    task automatic model(input logic rw, input int addr, input logic [1:0] size, input logic sgn,
                         input logic [31:0] wdata, output logic err, output logic [31:0] rd);
        int n;
        longint v;
        n   = nbytes(size);
        err = (n == 0);
        if (!err) err = (addr % n != 0) || (addr + n > MEM);
        rd  = 32'd0;
        if (!err) begin
            if (rw) begin
                for (int i = 0; i < n; i++) ref_mem[addr + i] = int'(wdata[8*i +: 8]);
            end else begin
                v = 0;
                for (int i = 0; i < n; i++) v += longint'(ref_mem[addr + i]) << (8 * i);
                if (sgn && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
                rd = v[31:0];
            end
        end
    endtask

    // ---------------- one transaction on dut ----------------
    task automatic txn(input string tag, input logic rw, input logic [AW-1:0] addr,
                       input logic [1:0] size, input logic sgn, input logic [31:0] wdata,
                       input int lat, input logic exp_err, input logic [31:0] exp_rd,
                       input int exp_cyc, input int exp_act);
        int   cyc, act;
        logic unstable;
        ram_lat = lat;
        @(negedge Clk);
        check({tag, " ready"}, 32'(req_ready), 32'd1);
        req_rw = rw; req_addr = addr; req_size = size; req_signed = sgn; req_wdata = wdata;
        req_valid = 1'b1;
        @(negedge Clk);
        // Keep a garbage request asserted while busy; it must be ignored.
        req_rw = ~rw; req_addr = ~addr; req_wdata = ~wdata;
        cyc = 1; act = 0; unstable = 1'b0;
        while (!resp_valid && cyc < 100) begin
            if (memFuncActive) begin
                act++;
                if (readWrite !== rw || address !== addr || dataSize !== size || dataIn !== wdata)
                    unstable = 1'b1;
            end
            @(negedge Clk);
            cyc++;
            req_valid = 1'b0;
        end
        req_valid = 1'b0;
        check({tag, " latency"}, 32'(cyc), 32'(exp_cyc));
        check({tag, " error"}, 32'(resp_error), 32'(exp_err));
        check({tag, " rdata"}, resp_rdata, exp_rd);
        check({tag, " active_cycles"}, 32'(act), 32'(exp_act));
        check({tag, " stable+idle_in_resp"}, {31'd0, unstable | memFuncActive}, 32'd0);
        @(negedge Clk);
        check({tag, " pulse_one_cycle"}, {30'd0, resp_valid, req_ready}, 32'd1);
    endtask

    task automatic na_txn(input string tag, input logic [AW-1:0] addr, input logic [1:0] size,
                          input logic sgn, input logic exp_err, input logic [31:0] exp_rd,
                          input int exp_cyc);
        int cyc;
        @(negedge Clk);
        n_addr = addr; n_size = size; n_signed = sgn; n_valid = 1'b1;
        @(negedge Clk);
        n_valid = 1'b0;
        cyc = 1;
        while (!n_rvalid && cyc < 50) begin
            @(negedge Clk);
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'(exp_cyc));
        check({tag, " error"}, 32'(n_rerr), 32'(exp_err));
        check({tag, " rdata"}, n_rdata, exp_rd);
    endtask

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [1:0]    size;
        logic          sgn;
        logic [31:0]   wdata;
        int            lat;
        logic          err;
        logic [31:0]   rd;
    } vec_t;

    vec_t vecs [15];

    initial begin
        logic        e_err;
        logic [31:0] e_rd;
        int          bad;

        vecs[0]  = '{1'b1, 9'h010, 2'b11, 1'b0, 32'hA1B2C3D4, 1, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 9'h010, 2'b11, 1'b0, 32'h0,        1, 1'b0, 32'hA1B2C3D4};
        vecs[2]  = '{1'b1, 9'h011, 2'b00, 1'b0, 32'h12345680, 2, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 9'h011, 2'b00, 1'b1, 32'h0,        1, 1'b0, 32'hFFFFFF80};
        vecs[4]  = '{1'b0, 9'h011, 2'b00, 1'b0, 32'h0,        3, 1'b0, 32'h00000080};
        vecs[5]  = '{1'b0, 9'h003, 2'b01, 1'b0, 32'h0,        1, 1'b1, 32'h0};
        vecs[6]  = '{1'b0, 9'h000, 2'b10, 1'b0, 32'h0,        1, 1'b1, 32'h0};
        vecs[7]  = '{1'b0, 9'h010, 2'b11, 1'b0, 32'h0,        1, 1'b0, 32'hA1B280D4};
        vecs[8]  = '{1'b0, 9'h012, 2'b01, 1'b1, 32'h0,        5, 1'b0, 32'hFFFFA1B2};
        vecs[9]  = '{1'b0, 9'h012, 2'b01, 1'b0, 32'h0,        2, 1'b0, 32'h0000A1B2};
        vecs[10] = '{1'b1, 9'h1FC, 2'b11, 1'b0, 32'hDEADBEEF, 1, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 9'h1FE, 2'b11, 1'b0, 32'h0,        1, 1'b1, 32'h0};
        vecs[12] = '{1'b0, 9'h1FF, 2'b00, 1'b1, 32'h0,        1, 1'b0, 32'hFFFFFFDE};
        vecs[13] = '{1'b0, 9'h1FC, 2'b11, 1'b0, 32'h0,        4, 1'b0, 32'hDEADBEEF};
        vecs[14] = '{1'b1, 9'h1FF, 2'b01, 1'b0, 32'h55AA,     1, 1'b1, 32'h0};

        for (int i = 0; i < MEM; i++) ref_mem[i] = 0;

        // Reset state
        repeat (2) @(negedge Clk);
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset resp/active/rw/err", {28'd0, resp_valid, memFuncActive, readWrite, resp_error}, 32'd0);
        check("reset address", 32'(address), 32'd0);
        check("reset dataIn", dataIn, 32'd0);
        check("reset dataSize+rdata", resp_rdata | 32'(dataSize), 32'd0);
        Reset = 1'b0;
        ram_init = 1'b0;

        // Directed vectors
        for (int i = 0; i < 15; i++) begin
            model(vecs[i].rw, int'(vecs[i].addr), vecs[i].size, vecs[i].sgn, vecs[i].wdata, e_err, e_rd);
            txn($sformatf("vec%0d", i), vecs[i].rw, vecs[i].addr, vecs[i].size, vecs[i].sgn,
                vecs[i].wdata, vecs[i].lat, vecs[i].err, vecs[i].rd,
                vecs[i].err ? 1 : vecs[i].lat + 2, vecs[i].err ? 0 : vecs[i].lat + 1);
        end

        // Reset while in WAIT: no response, handshake dropped, next access unaffected
        ram_lat = 8;
        @(negedge Clk);
        req_rw = 1'b0; req_addr = 9'h010; req_size = 2'b11; req_signed = 1'b0; req_valid = 1'b1;
        @(negedge Clk);
        req_valid = 1'b0;
        @(negedge Clk);
        check("rst_wait active_before", 32'(memFuncActive), 32'd1);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("rst_wait after", {29'd0, memFuncActive, req_ready, resp_valid}, 32'd2);
        bad = 0;
        repeat (10) begin
            @(negedge Clk);
            if (resp_valid || memFuncActive) bad++;
        end
        check("rst_wait no_resp", 32'(bad), 32'd0);
        model(1'b0, 16, 2'b11, 1'b0, 32'h0, e_err, e_rd);
        txn("after_rst", 1'b0, 9'h010, 2'b11, 1'b0, 32'h0, 1, e_err, e_rd, 3, 2);

        // No-alignment instance: bounds still enforced, misaligned half accepted
        na_txn("na word@1FE", 9'h1FE, 2'b11, 1'b0, 1'b1, 32'h0, 1);
        na_txn("na half@1FF", 9'h1FF, 2'b01, 1'b0, 1'b1, 32'h0, 1);
        na_txn("na half@003", 9'h003, 2'b01, 1'b1, 1'b0, 32'hFFFF8001, 3);
        na_txn("na byte@1FF", 9'h1FF, 2'b00, 1'b0, 1'b0, 32'h00000001, 3);

`ifdef MEMCTL_TIMEOUT_EN
        // RAM never completes: 1 ISSUE + 16 WAIT cycles, then error response
        txn("timeout", 1'b0, 9'h020, 2'b11, 1'b0, 32'h0, 100000, 1'b1, 32'h0, 18, 17);
`endif

        // Random traffic against the reference model
        for (int i = 0; i < 150; i++) begin
            logic          rw, sgn;
            logic [AW-1:0] a;
            logic [1:0]    s;
            logic [31:0]   wd;
            int            lat;
            rw  = 1'($urandom_range(0, 1));
            sgn = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, MEM - 1));
            s   = 2'($urandom_range(0, 3));
            wd  = $urandom;
            lat = $urandom_range(1, 6);
            model(rw, int'(a), s, sgn, wd, e_err, e_rd);
            txn($sformatf("rnd%0d", i), rw, a, s, sgn, wd, lat, e_err, e_rd,
                e_err ? 1 : lat + 2, e_err ? 0 : lat + 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
